// File: rtl/decode_stage.sv
// RV32I(+M) OP/OP_IMM decode stage.
// Registered output bundle behind valid/ready with a one-entry skid.
module decode_stage #(
  parameter int DATA_WIDTH        = 32,
  parameter int REGADDR_WIDTH     = 5,
  parameter int RESLT_SELCT_WIDTH = 3,
  parameter bit ENABLE_M          = 1'b1,
  parameter int CNT_WIDTH         = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [31:0]                  instr,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic [REGADDR_WIDTH-1:0]     a_location,
  output logic [REGADDR_WIDTH-1:0]     b_location,
  output logic                         immediateSelect,
  output logic [DATA_WIDTH-1:0]        immediateVal,
  output logic                         unsignedSelect,
  output logic                         subtractEnable,
  output logic [1:0]                   logicOp,
  output logic [1:0]                   shiftOp,
  output logic [REGADDR_WIDTH-1:0]     writeSelect,
  output logic                         writeEnable,
  output logic [RESLT_SELCT_WIDTH-1:0] resultSelect,
  output logic                         error,
  output logic [CNT_WIDTH-1:0]         illegal_count
);

  localparam logic [RESLT_SELCT_WIDTH-1:0] RS_ADD = 0;
  localparam logic [RESLT_SELCT_WIDTH-1:0] RS_MUL = 1;
  localparam logic [RESLT_SELCT_WIDTH-1:0] RS_DIV = 2;
  localparam logic [RESLT_SELCT_WIDTH-1:0] RS_REM = 3;
  localparam logic [RESLT_SELCT_WIDTH-1:0] RS_LOG = 4;
  localparam logic [RESLT_SELCT_WIDTH-1:0] RS_SLT = 5;
  localparam logic [RESLT_SELCT_WIDTH-1:0] RS_SHF = 6;

  typedef struct packed {
    logic [REGADDR_WIDTH-1:0]     a;
    logic [REGADDR_WIDTH-1:0]     b;
    logic                         imm_sel;
    logic [DATA_WIDTH-1:0]        imm;
    logic                         uns;
    logic                         sub;
    logic [1:0]                   lop;
    logic [1:0]                   sop;
    logic [REGADDR_WIDTH-1:0]     wsel;
    logic                         we;
    logic [RESLT_SELCT_WIDTH-1:0] rsel;
    logic                         err;
  } dec_t;

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       is_op;
  logic       is_imm;

  assign opc    = instr[6:0];
  assign f7     = instr[31:25];
  assign f3     = instr[14:12];
  assign is_op  = (opc == 7'h33);
  assign is_imm = (opc == 7'h13);

  dec_t d;
  logic legal;

  always_comb begin
    d       = '0;
    legal   = 1'b0;
    d.a     = REGADDR_WIDTH'(instr[19:15]);
    d.b     = REGADDR_WIDTH'(instr[24:20]);
    d.wsel  = REGADDR_WIDTH'(instr[11:7]);
    d.imm   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    unique case (1'b1)
      is_op && f7 == 7'h00: begin
        legal = 1'b1;
        unique case (f3)
          3'd0: d.rsel = RS_ADD;
          3'd1: begin d.rsel = RS_SHF; d.sop = 2'd0; end
          3'd2: d.rsel = RS_SLT;
          3'd3: begin d.rsel = RS_SLT; d.uns = 1'b1; end
          3'd4: begin d.rsel = RS_LOG; d.lop = 2'd0; end
          3'd5: begin d.rsel = RS_SHF; d.sop = 2'd1; end
          3'd6: begin d.rsel = RS_LOG; d.lop = 2'd1; end
          default: begin d.rsel = RS_LOG; d.lop = 2'd2; end
        endcase
      end
      is_op && f7 == 7'h20: begin
        if (f3 == 3'd0) begin
          legal = 1'b1;
          d.sub = 1'b1;
        end else if (f3 == 3'd5) begin
          legal  = 1'b1;
          d.rsel = RS_SHF;
          d.sop  = 2'd2;
        end
      end
      is_op && f7 == 7'h01 && ENABLE_M: begin
        legal = 1'b1;
        unique case (f3)
          3'd0: d.rsel = RS_MUL;
          3'd4: d.rsel = RS_DIV;
          3'd5: begin d.rsel = RS_DIV; d.uns = 1'b1; end
          3'd6: d.rsel = RS_REM;
          3'd7: begin d.rsel = RS_REM; d.uns = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      is_imm: begin
        legal     = 1'b1;
        d.imm_sel = 1'b1;
        unique case (f3)
          3'd0: d.rsel = RS_ADD;
          3'd2: d.rsel = RS_SLT;
          3'd3: begin d.rsel = RS_SLT; d.uns = 1'b1; end
          3'd4: begin d.rsel = RS_LOG; d.lop = 2'd0; end
          3'd6: begin d.rsel = RS_LOG; d.lop = 2'd1; end
          3'd7: begin d.rsel = RS_LOG; d.lop = 2'd2; end
          3'd1: begin
            d.rsel = RS_SHF;
            d.imm  = DATA_WIDTH'(instr[24:20]);
            legal  = (f7 == 7'h00);
          end
          default: begin
            d.rsel = RS_SHF;
            d.imm  = DATA_WIDTH'(instr[24:20]);
            d.sop  = (f7 == 7'h20) ? 2'd2 : 2'd1;
            legal  = (f7 == 7'h00) || (f7 == 7'h20);
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
    // illegal words carry a neutral control set
    if (!legal) begin
      d.rsel = '0;
      d.sub  = 1'b0;
      d.uns  = 1'b0;
      d.lop  = '0;
      d.sop  = '0;
    end
    d.err = !legal;
    d.we  = legal && (instr[11:7] != 5'd0);
  end

  dec_t                 out_q;
  dec_t                 skid_q;
  logic                 valid_q;
  logic                 skid_full;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 accept;
  logic                 load;

  assign accept = instr_valid && !skid_full;
  assign load   = !valid_q || dec_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      skid_q    <= '0;
      valid_q   <= 1'b0;
      skid_full <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (load) begin
        if (skid_full) begin
          out_q     <= skid_q;
          skid_full <= 1'b0;
          valid_q   <= 1'b1;
        end else if (accept) begin
          out_q   <= d;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q    <= d;
        skid_full <= 1'b1;
      end
      if (accept && d.err && cnt_q != '1)
        cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign instr_ready     = !skid_full;
  assign dec_valid       = valid_q;
  assign a_location      = out_q.a;
  assign b_location      = out_q.b;
  assign immediateSelect = out_q.imm_sel;
  assign immediateVal    = out_q.imm;
  assign unsignedSelect  = out_q.uns;
  assign subtractEnable  = out_q.sub;
  assign logicOp         = out_q.lop;
  assign shiftOp         = out_q.sop;
  assign writeSelect     = out_q.wsel;
  assign writeEnable     = out_q.we;
  assign resultSelect    = out_q.rsel;
  assign error           = out_q.err;
  assign illegal_count   = cnt_q;

endmodule
